// File: rtl/fifo_pkg.sv
// +--------------------------------------------------------------------+
// | fifo_pkg : width helpers, reset constants and parameter checks     |
// | Revision : 1.0                                                     |
// +--------------------------------------------------------------------+
`default_nettype none

package fifo_pkg;

  localparam logic RST_ERR_PULSE = 1'b0;
  localparam int   RST_OCCUPANCY = 0;

  function automatic int ptr_width(input int depth);
    return $clog2(depth);
  endfunction

  // One extra bit so the count can hold DEPTH itself.
  function automatic int count_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

  function automatic bit depth_legal(input int depth);
    return (depth >= 2) && ((depth & (depth - 1)) == 0);
  endfunction

  function automatic bit af_legal(input int af_level, input int depth);
    return (af_level >= 1) && (af_level <= depth);
  endfunction

  function automatic bit ae_legal(input int ae_level, input int depth);
    return (ae_level >= 0) && (ae_level <= depth - 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/fifo_mem_dp.sv
// +--------------------------------------------------------------------+
// | fifo_mem_dp : DEPTH x WIDTH storage, sync write, async read        |
// | Revision    : 1.0                                                  |
// +--------------------------------------------------------------------+
`default_nettype none

module fifo_mem_dp
  import fifo_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  parameter int AW    = ptr_width(DEPTH)
) (
  input  logic             clk,
  input  logic             i_we,
  input  logic [AW-1:0]    i_waddr,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic [AW-1:0]    i_raddr,
  output logic [WIDTH-1:0] o_rdata
);

  logic [WIDTH-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

`default_nettype wire

// File: rtl/sync_fifo_param.sv
// +--------------------------------------------------------------------+
// | sync_fifo_param : parametrised single-clock FIFO with AF/AE flags, |
// |   flush and overflow/underflow pulses. SYNC_FIFO_FWFT_EN selects   |
// |   first-word-fall-through output.                                  |
// | Revision        : 1.0                                              |
// +--------------------------------------------------------------------+
`default_nettype none

module sync_fifo_param
  import fifo_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int DEPTH    = 16,
  parameter int AF_LEVEL = 14,
  parameter int AE_LEVEL = 2
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          flush,
  input  logic                          write,
  input  logic [WIDTH-1:0]              buff_in,
  input  logic                          read,
  output logic [WIDTH-1:0]              buff_out,
  output logic                          full,
  output logic                          empty,
  output logic                          almost_full,
  output logic                          almost_empty,
  output logic [count_width(DEPTH)-1:0] fifo_count,
  output logic                          overflow,
  output logic                          underflow
);

  localparam int AW = ptr_width(DEPTH);
  localparam int CW = count_width(DEPTH);

  generate
    if (!depth_legal(DEPTH)) begin : g_bad_depth
      $error("sync_fifo_param: DEPTH must be a power of 2 and >= 2");
    end
    if (!af_legal(AF_LEVEL, DEPTH)) begin : g_bad_af
      $error("sync_fifo_param: AF_LEVEL must be in 1..DEPTH");
    end
    if (!ae_legal(AE_LEVEL, DEPTH)) begin : g_bad_ae
      $error("sync_fifo_param: AE_LEVEL must be in 0..DEPTH-1");
    end
  endgenerate

  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             r_overflow;
  logic             r_underflow;
  logic             w_wr_ok;
  logic             w_rd_ok;
  logic             w_mem_we;
  logic [WIDTH-1:0] w_rd_data;

  // Flags come straight from the registered count, so accept decisions never
  // depend on same-cycle requests.
  assign full         = (r_count == CW'(DEPTH));
  assign empty        = (r_count == '0);
  assign almost_full  = (r_count >= CW'(AF_LEVEL));
  assign almost_empty = (r_count <= CW'(AE_LEVEL));
  assign fifo_count   = r_count;
  assign overflow     = r_overflow;
  assign underflow    = r_underflow;

  assign w_wr_ok  = write & ~full;
  assign w_rd_ok  = read & ~empty;
  assign w_mem_we = w_wr_ok & ~flush;

  fifo_mem_dp #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .clk     (clk),
    .i_we    (w_mem_we),
    .i_waddr (r_wr_ptr),
    .i_wdata (buff_in),
    .i_raddr (r_rd_ptr),
    .o_rdata (w_rd_data)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= CW'(RST_OCCUPANCY);
      r_overflow  <= RST_ERR_PULSE;
      r_underflow <= RST_ERR_PULSE;
    end else if (flush) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= CW'(RST_OCCUPANCY);
      r_overflow  <= RST_ERR_PULSE;
      r_underflow <= RST_ERR_PULSE;
    end else begin
      r_overflow  <= write & full;
      r_underflow <= read & empty;
      if (w_wr_ok) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_rd_ok) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      if (w_wr_ok && !w_rd_ok) begin
        r_count <= r_count + CW'(1);
      end else if (w_rd_ok && !w_wr_ok) begin
        r_count <= r_count - CW'(1);
      end
    end
  end

`ifdef SYNC_FIFO_FWFT_EN
  assign buff_out = empty ? '0 : w_rd_data;
`else
  logic [WIDTH-1:0] r_dout;

  // Output register holds through flush; only a real pop reloads it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_dout <= '0;
    end else if (w_rd_ok && !flush) begin
      r_dout <= w_rd_data;
    end
  end

  assign buff_out = r_dout;
`endif

endmodule

`default_nettype wire

// File: tb/tb_sync_fifo_param.sv
// +--------------------------------------------------------------------+
// | tb_sync_fifo_param : self-checking bench for sync_fifo_param       |
// | Revision           : 1.0                                           |
// +--------------------------------------------------------------------+
`default_nettype none

module tb_sync_fifo_param;

  localparam int DEPTH = 16;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       flush = 1'b0;
  logic       write = 1'b0;
  logic       read = 1'b0;
  logic [7:0] buff_in = '0;
  logic [7:0] buff_out;
  logic       full, empty, almost_full, almost_empty, overflow, underflow;
  logic [4:0] fifo_count;

  logic [7:0] q[$];
  logic [7:0] m_dout;
  bit         m_ovf, m_unf;
  int         n_checks = 0;
  int         n_errors = 0;

  sync_fifo_param #(
    .WIDTH    (8),
    .DEPTH    (DEPTH),
    .AF_LEVEL (14),
    .AE_LEVEL (2)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .flush        (flush),
    .write        (write),
    .buff_in      (buff_in),
    .read         (read),
    .buff_out     (buff_out),
    .full         (full),
    .empty        (empty),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .fifo_count   (fifo_count),
    .overflow     (overflow),
    .underflow    (underflow)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  function automatic logic [7:0] exp_out();
`ifdef SYNC_FIFO_FWFT_EN
    return (q.size() != 0) ? q[0] : 8'h00;
`else
    return m_dout;
`endif
  endfunction

  function automatic logic [3:0] exp_flags();
    int n = q.size();
    return {n == 0, n == DEPTH, n <= 2, n >= 14};
  endfunction

  task automatic model_reset();
    q.delete();
    m_dout = 8'h00;
    m_ovf  = 1'b0;
    m_unf  = 1'b0;
  endtask

  // Drive one clock of requests and advance the reference model.
  task automatic cycle(input bit wr, input bit rd, input bit fl, input logic [7:0] d);
    int n;
    write   = wr;
    read    = rd;
    flush   = fl;
    buff_in = d;
    @(posedge clk);
    n = q.size();
    if (fl) begin
      q.delete();
      m_ovf = 1'b0;
      m_unf = 1'b0;
    end else begin
      m_ovf = wr && (n == DEPTH);
      m_unf = rd && (n == 0);
      if (rd && n > 0) m_dout = q.pop_front();
      if (wr && n < DEPTH) q.push_back(d);
    end
    #1;
    write = 1'b0;
    read  = 1'b0;
    flush = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    n_checks++;
    if (fifo_count !== 5'd0) begin
      n_errors++; $display("FAIL reset_count: got %0d expected 0", fifo_count);
    end
    n_checks++;
    if ({empty, full, almost_empty, almost_full, overflow, underflow} !== 6'b101000) begin
      n_errors++;
      $display("FAIL reset_flags: got %b expected 101000",
               {empty, full, almost_empty, almost_full, overflow, underflow});
    end
    n_checks++;
    if (buff_out !== 8'h00) begin
      n_errors++; $display("FAIL reset_dout: got %h expected 00", buff_out);
    end
    reset = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_fill_drain();
    for (int i = 0; i < 5; i++) begin
      cycle(1'b1, 1'b0, 1'b0, 8'hA1 + 8'(i));
      n_checks++;
      if (fifo_count !== 5'(i + 1)) begin
        n_errors++; $display("FAIL fill_count: got %0d expected %0d", fifo_count, i + 1);
      end
      n_checks++;
      if (empty !== 1'b0 || almost_empty !== 1'(i + 1 <= 2)) begin
        n_errors++;
        $display("FAIL fill_flags: empty=%b ae=%b expected empty=0 ae=%b",
                 empty, almost_empty, 1'(i + 1 <= 2));
      end
    end
    for (int i = 0; i < 5; i++) begin
`ifdef SYNC_FIFO_FWFT_EN
      n_checks++;
      if (buff_out !== 8'hA1 + 8'(i)) begin
        n_errors++; $display("FAIL fwft_head: got %h expected %h", buff_out, 8'hA1 + 8'(i));
      end
`endif
      cycle(1'b0, 1'b1, 1'b0, 8'h00);
`ifndef SYNC_FIFO_FWFT_EN
      n_checks++;
      if (buff_out !== 8'hA1 + 8'(i)) begin
        n_errors++; $display("FAIL drain_data: got %h expected %h", buff_out, 8'hA1 + 8'(i));
      end
`endif
    end
    n_checks++;
    if (empty !== 1'b1 || fifo_count !== 5'd0) begin
      n_errors++; $display("FAIL drain_end: empty=%b count=%0d expected 1/0", empty, fifo_count);
    end
  endtask

  task automatic test_overflow();
    for (int i = 0; i < DEPTH; i++) begin
      cycle(1'b1, 1'b0, 1'b0, 8'($urandom));
      n_checks++;
      if (fifo_count !== 5'(q.size()) || {empty, full, almost_empty, almost_full} !== exp_flags()) begin
        n_errors++;
        $display("FAIL ovf_fill: count=%0d flags=%b expected %0d/%b", fifo_count,
                 {empty, full, almost_empty, almost_full}, q.size(), exp_flags());
      end
    end
    cycle(1'b1, 1'b0, 1'b0, 8'h5A);
    n_checks++;
    if (fifo_count !== 5'd16 || overflow !== 1'b1) begin
      n_errors++; $display("FAIL ovf_pulse: count=%0d ovf=%b expected 16/1", fifo_count, overflow);
    end
    cycle(1'b0, 1'b0, 1'b0, 8'h00);
    n_checks++;
    if (overflow !== 1'b0) begin
      n_errors++; $display("FAIL ovf_clear: got %b expected 0", overflow);
    end
    for (int i = 0; i < DEPTH; i++) begin
      cycle(1'b0, 1'b1, 1'b0, 8'h00);
      n_checks++;
      if (buff_out !== exp_out()) begin
        n_errors++; $display("FAIL ovf_readback: got %h expected %h", buff_out, exp_out());
      end
    end
  endtask

  task automatic test_underflow();
    cycle(1'b0, 1'b1, 1'b0, 8'h00);
    n_checks++;
    if (underflow !== 1'b1 || fifo_count !== 5'd0 || buff_out !== exp_out()) begin
      n_errors++;
      $display("FAIL unf_pulse: unf=%b count=%0d dout=%h expected 1/0/%h",
               underflow, fifo_count, buff_out, exp_out());
    end
    cycle(1'b0, 1'b0, 1'b0, 8'h00);
    n_checks++;
    if (underflow !== 1'b0) begin
      n_errors++; $display("FAIL unf_clear: got %b expected 0", underflow);
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 8; i++) cycle(1'b1, 1'b0, 1'b0, 8'($urandom));
    for (int i = 0; i < 10; i++) begin
      cycle(1'b1, 1'b1, 1'b0, 8'($urandom));
      n_checks++;
      if (fifo_count !== 5'd8 || buff_out !== exp_out()) begin
        n_errors++;
        $display("FAIL b2b: count=%0d dout=%h expected 8/%h", fifo_count, buff_out, exp_out());
      end
    end
    for (int i = 0; i < 8; i++) begin
      cycle(1'b0, 1'b1, 1'b0, 8'h00);
      n_checks++;
      if (buff_out !== exp_out()) begin
        n_errors++; $display("FAIL b2b_drain: got %h expected %h", buff_out, exp_out());
      end
    end
  endtask

  task automatic test_full_empty_rw();
    for (int i = 0; i < DEPTH; i++) cycle(1'b1, 1'b0, 1'b0, 8'($urandom));
    cycle(1'b1, 1'b1, 1'b0, 8'($urandom));
    n_checks++;
    if (fifo_count !== 5'd15 || overflow !== 1'b1 || underflow !== 1'b0 || buff_out !== exp_out()) begin
      n_errors++;
      $display("FAIL full_rw: count=%0d ovf=%b unf=%b dout=%h expected 15/1/0/%h",
               fifo_count, overflow, underflow, buff_out, exp_out());
    end
    for (int i = 0; i < 15; i++) begin
      cycle(1'b0, 1'b1, 1'b0, 8'h00);
      n_checks++;
      if (buff_out !== exp_out()) begin
        n_errors++; $display("FAIL full_rw_drain: got %h expected %h", buff_out, exp_out());
      end
    end
    cycle(1'b1, 1'b1, 1'b0, 8'($urandom));
    n_checks++;
    if (fifo_count !== 5'd1 || underflow !== 1'b1 || overflow !== 1'b0 || buff_out !== exp_out()) begin
      n_errors++;
      $display("FAIL empty_rw: count=%0d unf=%b ovf=%b dout=%h expected 1/1/0/%h",
               fifo_count, underflow, overflow, buff_out, exp_out());
    end
    cycle(1'b0, 1'b1, 1'b0, 8'h00);
    n_checks++;
    if (buff_out !== exp_out() || empty !== 1'b1) begin
      n_errors++; $display("FAIL empty_rw_read: dout=%h empty=%b expected %h/1", buff_out, empty, exp_out());
    end
  endtask

  task automatic test_flush();
    for (int i = 0; i < 9; i++) cycle(1'b1, 1'b0, 1'b0, 8'($urandom));
    cycle(1'b1, 1'b0, 1'b1, 8'($urandom));
    n_checks++;
    if (fifo_count !== 5'd0 || empty !== 1'b1 || overflow !== 1'b0 || buff_out !== exp_out()) begin
      n_errors++;
      $display("FAIL flush9: count=%0d empty=%b ovf=%b dout=%h expected 0/1/0/%h",
               fifo_count, empty, overflow, buff_out, exp_out());
    end
    for (int i = 0; i < DEPTH; i++) cycle(1'b1, 1'b0, 1'b0, 8'($urandom));
    cycle(1'b1, 1'b0, 1'b1, 8'($urandom));
    n_checks++;
    if (fifo_count !== 5'd0 || overflow !== 1'b0 || almost_full !== 1'b0) begin
      n_errors++;
      $display("FAIL flush_full: count=%0d ovf=%b af=%b expected 0/0/0", fifo_count, overflow, almost_full);
    end
    cycle(1'b1, 1'b0, 1'b0, 8'h3C);
    cycle(1'b0, 1'b1, 1'b0, 8'h00);
    n_checks++;
    if (buff_out !== exp_out()) begin
      n_errors++; $display("FAIL flush_recover: got %h expected %h", buff_out, exp_out());
    end
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 6; i++) cycle(1'b1, 1'b0, 1'b0, 8'($urandom));
    cycle(1'b0, 1'b1, 1'b0, 8'h00);
    #3;
    reset = 1'b1;
    #1;
    model_reset();
    n_checks++;
    if (fifo_count !== 5'd0 || buff_out !== 8'h00 ||
        {empty, full, almost_empty, almost_full, overflow, underflow} !== 6'b101000) begin
      n_errors++;
      $display("FAIL async_reset: count=%0d dout=%h flags=%b expected 0/00/101000", fifo_count,
               buff_out, {empty, full, almost_empty, almost_full, overflow, underflow});
    end
    @(posedge clk);
    #1;
    reset = 1'b0;
    cycle(1'b1, 1'b0, 1'b0, 8'hC3);
    cycle(1'b0, 1'b1, 1'b0, 8'h00);
    n_checks++;
    if (buff_out !== exp_out() || fifo_count !== 5'd0) begin
      n_errors++;
      $display("FAIL post_reset: dout=%h count=%0d expected %h/0", buff_out, fifo_count, exp_out());
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      bit wr_heavy = ((c / 40) % 2) == 0;
      bit wr = ($urandom_range(99) < (wr_heavy ? 80 : 25));
      bit rd = ($urandom_range(99) < (wr_heavy ? 25 : 80));
      bit fl = ($urandom_range(99) == 0);
      cycle(wr, rd, fl, 8'($urandom));
      n_checks++;
      if (fifo_count !== 5'(q.size()) || {empty, full, almost_empty, almost_full} !== exp_flags() ||
          overflow !== m_ovf || underflow !== m_unf || buff_out !== exp_out()) begin
        n_errors++;
        $display("FAIL random[%0d]: count=%0d flags=%b ovf=%b unf=%b dout=%h expected %0d/%b/%b/%b/%h",
                 c, fifo_count, {empty, full, almost_empty, almost_full}, overflow, underflow,
                 buff_out, q.size(), exp_flags(), m_ovf, m_unf, exp_out());
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_fill_drain();
    test_overflow();
    test_underflow();
    test_back_to_back();
    test_full_empty_rw();
    test_flush();
    test_async_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
